asin_search: RTL and testbench
==============================

ASIN_SEARCH -- requirements
Module: asin_search

Interface
REQ-001 Parameter ROUND_NEAREST, default 1, 1 = round to nearest degree, 0 = floor (largest degree whose sine <= |amp|).
REQ-002 clk_in  input  1  system clock; all logic on rising edge.
REQ-003 rst_in  input  1  reset, synchronous and active-high.
REQ-004 amp_in  input  32  signed two's-complement amplitude, Q16.16 (1.0 = 0x0001_0000).
REQ-005 amp_valid_in  input  1  amp_in valid this cycle.
REQ-006 ready_out  output  1  block idle and able to accept; accept occurs on amp_valid_in && ready_out.
REQ-007 angle_out  output  9  unsigned angle in degrees, range 0..359, same angle convention as sine/cosine blocks.
REQ-008 valid_out  output  1  angle_out valid; held until consumed.
REQ-009 out_ready_in  input  1  consumer accepts angle_out when valid_out && out_ready_in.

Function
REQ-010 Block SHALL compute the inverse of the sine table: angle a with sin(a) closest to amp_in, a in 0..90 or 270..359.
REQ-011 On accept, block SHALL register mag = min(|amp_in|, 0x0001_0000) and sign = amp_in[31]; amp_in = 0x8000_0000 treated as magnitude 0x0001_0000.
REQ-012 States: IDLE, ISSUE, COMPARE, REFINE_ISSUE, REFINE_CMP, HOLD; ready_out high only in IDLE.
REQ-013 Search SHALL build d (7 bits) MSB-first over bits 64,32,16,8,4,2,1: candidate = d | bit; ISSUE drives candidate to ROM; COMPARE sets d = candidate iff candidate <= 90 and rom(candidate) <= mag.
REQ-014 Candidates > 90 SHALL still consume ISSUE+COMPARE cycles (fixed latency); ROM address clamped to 90 for them.
REQ-015 REFINE: if ROUND_NEAREST=1 and d < 90, look up rom(d+1); choose d+1 iff (rom(d+1) - mag) < (mag - rom(d)); ties keep d. Otherwise d unchanged; REFINE cycles still spent.
REQ-016 Output mapping: sign=0 or d=0 -> angle_out = d; sign=1 and d>0 -> angle_out = 360 - d. Never output 360.
REQ-017 Latency: valid_out SHALL rise exactly 17 cycles after the accepting edge (7x2 search + 2 refine + 1 output register).
REQ-018 In HOLD, angle_out and valid_out SHALL stay stable until out_ready_in; on consume, next cycle valid_out=0, state IDLE, ready_out=1.
REQ-019 amp_valid_in outside IDLE SHALL be ignored; no input buffering.
REQ-020 Comparisons SHALL be unsigned 17-bit (mag and table values both <= 0x0001_0000); differences 17-bit unsigned, no overflow.

Reset
REQ-021 While rst_in high: state IDLE, valid_out=0, angle_out=0, ready_out=1 on the cycle after rst_in is sampled high, internal d/mag/sign cleared.
REQ-022 Reset mid-search or in HOLD SHALL abort the operation with no output pulse; next accept after rst_in low behaves as fresh.

Structure
REQ-023 Shared package sine_pkg SHALL hold ANGLE_W=9, AMP_W=32, ONE_Q16=32'h0001_0000, QUARTER_DEG=90, FULL_DEG=360, and the state enum.
REQ-024 One sub-module sine_quarter_rom: 7-bit address 0..90, 17-bit registered output (1-cycle latency), entry = round(sin(d deg)*65536), entry 0 = 0, entry 30 = 0x8000, entry 90 = 0x1_0000; address > 90 returns 0x1_0000.
REQ-025 Same ROM instance SHALL serve search and refine phases; no combinational path from amp_in to angle_out.

Verification
REQ-026 amp_in=0x0000_8000, out_ready_in=1 -> valid_out 17 cycles after accept, angle_out=30.
REQ-027 amp_in=0x0001_0000, then 0x7FFF_FFFF -> angle_out=90 both; amp_in=0x8000_0000 -> 270; amp_in=0 -> 0.
REQ-028 amp_in=0xFFFF_8000 (-0.5) -> 330; amp_in=0x0000_8100 -> 30 (ROUND_NEAREST=1); amp_in=0x0000_83D0 -> 30 with ROUND_NEAREST=0, 31 with ROUND_NEAREST=1.
REQ-029 amp_in=0x0000_8000 with out_ready_in low 5 cycles after valid_out -> angle_out=30 and valid_out held stable; ready_out low throughout; amp_valid_in pulses during this time ignored.
REQ-030 rst_in asserted 8 cycles after accept -> no valid_out, ready_out=1 after reset; next input 0x0000_B505 -> 45.
REQ-031 Sweep: feed rom(d) for d=0..90 with sign both ways -> angle_out = d or (d>0 ? 360-d : 0) every case.

Source files
------------

// File: rtl/sine_pkg.sv
// Shared types and constants for the sine/cosine/arcsine blocks.
package sine_pkg;

    localparam int ANGLE_W = 9;
    localparam int AMP_W   = 32;
    localparam int MAG_W   = 17;
    localparam int ADDR_W  = 7;

    localparam logic [AMP_W-1:0]   ONE_Q16     = 32'h0001_0000;
    localparam logic [MAG_W-1:0]   MAG_ONE     = 17'h1_0000;
    localparam logic [ADDR_W-1:0]  QUARTER_DEG = 7'd90;
    localparam logic [ANGLE_W-1:0] FULL_DEG    = 9'd360;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        COMPARE,
        REFINE_ISSUE,
        REFINE_CMP,
        HOLD
    } state_t;

    // Fold a first-quadrant result into the full circle: negative amplitudes
    // land in 270..359, and zero stays zero so 360 is never produced.
    function automatic logic [ANGLE_W-1:0] map_angle(input logic sign,
                                                     input logic [ADDR_W-1:0] deg);
        logic [ANGLE_W-1:0] deg_ext;
        deg_ext = ANGLE_W'(deg);
        if (sign && (deg != '0))
            return FULL_DEG - deg_ext;
        else
            return deg_ext;
    endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine table, round(sin(d deg) * 65536) for d = 0..90,
// with a registered read. Addresses past 90 read back full scale.
module sine_quarter_rom
    import sine_pkg::*;
(
    input  logic              clk_in,
    input  logic [ADDR_W-1:0] addr_in,
    output logic [MAG_W-1:0]  data_out
);

    localparam int SINE_TBL [0:90] = '{
            0,  1144,  2287,  3430,  4572,  5712,  6850,  7987,  9121, 10252,
        11380, 12505, 13626, 14742, 15855, 16962, 18064, 19161, 20252, 21336,
        22415, 23486, 24550, 25607, 26656, 27697, 28729, 29753, 30767, 31772,
        32768, 33754, 34729, 35693, 36647, 37590, 38521, 39441, 40348, 41243,
        42126, 42995, 43852, 44695, 45525, 46341, 47143, 47930, 48703, 49461,
        50203, 50931, 51643, 52339, 53020, 53684, 54332, 54963, 55578, 56175,
        56756, 57319, 57865, 58393, 58903, 59396, 59870, 60326, 60764, 61183,
        61584, 61966, 62328, 62672, 62997, 63303, 63589, 63856, 64104, 64332,
        64540, 64729, 64898, 65048, 65177, 65287, 65376, 65446, 65496, 65526,
        65536
    };

    logic [MAG_W-1:0] rom_mem [0:90];
    logic [MAG_W-1:0] data_reg;

    generate
        for (genvar gi = 0; gi <= 90; gi++) begin : g_rom
            assign rom_mem[gi] = MAG_W'(SINE_TBL[gi]);
        end
    endgenerate

    // Registered read; out-of-range addresses saturate to sin(90).
    always_ff @(posedge clk_in) begin
        if (addr_in > QUARTER_DEG)
            data_reg <= MAG_ONE;
        else
            data_reg <= rom_mem[addr_in];
    end

    assign data_out = data_reg;

endmodule

// File: rtl/asin_search.sv
// Arcsine by binary search over the quarter-wave sine table, followed by an
// optional round-to-nearest step. Fixed 17-cycle latency, one op in flight.
module asin_search
    import sine_pkg::*;
#(
    parameter int ROUND_NEAREST = 1
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [AMP_W-1:0]   amp_in,
    input  logic               amp_valid_in,
    output logic               ready_out,
    output logic [ANGLE_W-1:0] angle_out,
    output logic               valid_out,
    input  logic               out_ready_in
);

    state_t state_reg, state_next;

    logic [ADDR_W-1:0]  d_reg, d_next;
    logic [ADDR_W-1:0]  bit_reg, bit_next;
    logic [MAG_W-1:0]   mag_reg, mag_next;
    logic [MAG_W-1:0]   lo_reg, lo_next;     // table value at the current d
    logic               sign_reg, sign_next;
    logic               valid_reg;
    logic [ANGLE_W-1:0] angle_reg;

    logic [AMP_W-1:0]  amp_abs;
    logic [MAG_W-1:0]  amp_mag;
    logic [ADDR_W-1:0] cand;
    logic [ADDR_W-1:0] search_addr;
    logic [ADDR_W-1:0] refine_addr;
    logic [ADDR_W-1:0] rom_addr;
    logic [MAG_W-1:0]  rom_data;
    logic [MAG_W-1:0]  up_diff;
    logic [MAG_W-1:0]  dn_diff;
    logic              round_up;
    logic              consume;

    // Magnitude clamped to 1.0; the most negative input wraps to a huge
    // unsigned value and therefore also clamps to 1.0.
    assign amp_abs = amp_in[AMP_W-1] ? (~amp_in + 32'd1) : amp_in;
    assign amp_mag = (amp_abs > ONE_Q16) ? MAG_ONE : amp_abs[MAG_W-1:0];

    assign cand        = d_reg | bit_reg;
    assign search_addr = (cand > QUARTER_DEG) ? QUARTER_DEG : cand;
    assign refine_addr = (d_reg < QUARTER_DEG) ? (d_reg + 7'd1) : QUARTER_DEG;
    assign rom_addr    = (state_reg == REFINE_ISSUE) ? refine_addr : search_addr;

    // d is the largest angle with table(d) <= mag, so both differences are >= 0.
    assign up_diff  = rom_data - mag_reg;
    assign dn_diff  = mag_reg - lo_reg;
    assign round_up = (ROUND_NEAREST != 0) && (d_reg < QUARTER_DEG) && (up_diff < dn_diff);

    assign consume   = valid_reg && out_ready_in;
    assign ready_out = (state_reg == IDLE);
    assign valid_out = valid_reg;
    assign angle_out = angle_reg;

    sine_quarter_rom u_rom (
        .clk_in   (clk_in),
        .addr_in  (rom_addr),
        .data_out (rom_data)
    );

    // State and datapath registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg <= IDLE;
            d_reg     <= '0;
            bit_reg   <= '0;
            mag_reg   <= '0;
            lo_reg    <= '0;
            sign_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            d_reg     <= d_next;
            bit_reg   <= bit_next;
            mag_reg   <= mag_next;
            lo_reg    <= lo_next;
            sign_reg  <= sign_next;
        end
    end

    // Next-state and search/refine decisions.
    always_comb begin
        state_next = state_reg;
        d_next     = d_reg;
        bit_next   = bit_reg;
        mag_next   = mag_reg;
        lo_next    = lo_reg;
        sign_next  = sign_reg;
        case (state_reg)
            IDLE: begin
                if (amp_valid_in) begin
                    mag_next   = amp_mag;
                    sign_next  = amp_in[AMP_W-1];
                    d_next     = '0;
                    lo_next    = '0;
                    bit_next   = 7'b100_0000;
                    state_next = ISSUE;
                end
            end
            ISSUE: state_next = COMPARE;
            COMPARE: begin
                if ((cand <= QUARTER_DEG) && (rom_data <= mag_reg)) begin
                    d_next  = cand;
                    lo_next = rom_data;
                end
                bit_next   = bit_reg >> 1;
                state_next = bit_reg[0] ? REFINE_ISSUE : ISSUE;
            end
            REFINE_ISSUE: state_next = REFINE_CMP;
            REFINE_CMP: begin
                if (round_up)
                    d_next = d_reg + 7'd1;
                state_next = HOLD;
            end
            HOLD: begin
                if (consume)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output register: loads once on entering HOLD, drops on consume.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_reg <= 1'b0;
            angle_reg <= '0;
        end else if ((state_reg == HOLD) && !valid_reg) begin
            valid_reg <= 1'b1;
            angle_reg <= map_angle(sign_reg, d_reg);
        end else if (consume) begin
            valid_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_asin_search.sv
// Directed bench for asin_search: nearest and floor variants run in lockstep.
module tb_asin_search;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] amp_in;
    logic        amp_valid_in;
    logic        out_ready_in;

    logic        ready_n, valid_n, ready_f, valid_f;
    logic [8:0]  angle_n, angle_f;

    int n_vec  = 0;
    int n_miss = 0;
    logic [31:0] cur_amp = '0;

    always #5 clk_in = ~clk_in;

    asin_search #(.ROUND_NEAREST(1)) dut_near (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .amp_in       (amp_in),
        .amp_valid_in (amp_valid_in),
        .ready_out    (ready_n),
        .angle_out    (angle_n),
        .valid_out    (valid_n),
        .out_ready_in (out_ready_in)
    );

    asin_search #(.ROUND_NEAREST(0)) dut_floor (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .amp_in       (amp_in),
        .amp_valid_in (amp_valid_in),
        .ready_out    (ready_f),
        .angle_out    (angle_f),
        .valid_out    (valid_f),
        .out_ready_in (out_ready_in)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s amp=%08h: got %0d expected %0d", tag, cur_amp, got, exp);
        end
    endtask

    // Accept one amplitude, wait for the result, check latency/angles, consume.
    task automatic run_vec(input string tag, input logic [31:0] amp,
                           input int exp_near, input int exp_floor);
        int lat;
        @(negedge clk_in);
        cur_amp = amp;
        check_val("ready_before", int'(ready_n), 1);
        amp_in       = amp;
        amp_valid_in = 1'b1;
        out_ready_in = 1'b1;
        @(posedge clk_in);
        #1;
        amp_valid_in = 1'b0;
        lat = 0;
        while (valid_n !== 1'b1 && lat < 40) begin
            @(posedge clk_in);
            #1;
            lat++;
        end
        check_val("latency", lat, 17);
        check_val("angle_near", int'(angle_n), exp_near);
        check_val("valid_floor", int'(valid_f), 1);
        check_val("angle_floor", int'(angle_f), exp_floor);
        $display("vec %s amp=%08h near=%0d floor=%0d lat=%0d", tag, amp, angle_n, angle_f, lat);
        @(posedge clk_in);
        #1;
        check_val("valid_after_consume", int'(valid_n), 0);
        check_val("ready_after_consume", int'(ready_n), 1);
    endtask

    initial begin
        real         r;
        int          v;
        int          lat;
        int          seen;
        logic [31:0] a;

        rst_in       = 1'b1;
        amp_in       = '0;
        amp_valid_in = 1'b0;
        out_ready_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        check_val("rst_ready", int'(ready_n), 1);
        check_val("rst_valid", int'(valid_n), 0);
        check_val("rst_angle", int'(angle_n), 0);
        check_val("rst_angle_floor", int'(angle_f), 0);
        rst_in = 1'b0;

        // Directed vectors.
        run_vec("half",      32'h0000_8000, 30, 30);
        run_vec("one",       32'h0001_0000, 90, 90);
        run_vec("max_pos",   32'h7FFF_FFFF, 90, 90);
        run_vec("min_neg",   32'h8000_0000, 270, 270);
        run_vec("zero",      32'h0000_0000, 0, 0);
        run_vec("neg_half",  32'hFFFF_8000, 330, 330);
        run_vec("x8100",     32'h0000_8100, 30, 30);
        run_vec("x83d0",     32'h0000_83D0, 31, 30);
        run_vec("neg_x83d0", 32'hFFFF_7C30, 329, 330);

        // Output held while the consumer stalls; input pulses ignored.
        @(negedge clk_in);
        cur_amp      = 32'h0000_8000;
        amp_in       = 32'h0000_8000;
        amp_valid_in = 1'b1;
        out_ready_in = 1'b0;
        @(posedge clk_in);
        #1;
        amp_valid_in = 1'b0;
        check_val("stall_busy_ready", int'(ready_n), 0);
        lat = 0;
        while (valid_n !== 1'b1 && lat < 40) begin
            amp_in       = 32'h0001_0000;
            amp_valid_in = lat[0];
            @(posedge clk_in);
            #1;
            lat++;
            if (valid_n !== 1'b1)
                check_val("stall_search_ready", int'(ready_n), 0);
        end
        amp_valid_in = 1'b0;
        check_val("stall_latency", lat, 17);
        for (int i = 0; i < 5; i++) begin
            amp_in       = 32'hFFFF_0000;
            amp_valid_in = 1'b1;
            @(posedge clk_in);
            #1;
            check_val("stall_valid", int'(valid_n), 1);
            check_val("stall_angle", int'(angle_n), 30);
            check_val("stall_ready", int'(ready_n), 0);
        end
        $display("vec stall amp=%08h near=%0d held 5 cycles", cur_amp, angle_n);
        amp_valid_in = 1'b0;
        out_ready_in = 1'b1;
        @(posedge clk_in);
        #1;
        check_val("stall_consumed_valid", int'(valid_n), 0);
        check_val("stall_consumed_ready", int'(ready_n), 1);
        run_vec("after_stall", 32'h0000_0000, 0, 0);

        // Reset part-way through a search aborts it without an output pulse.
        @(negedge clk_in);
        cur_amp      = 32'h0000_8000;
        amp_in       = 32'h0000_8000;
        amp_valid_in = 1'b1;
        @(posedge clk_in);
        #1;
        amp_valid_in = 1'b0;
        repeat (7) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        check_val("abort_ready", int'(ready_n), 1);
        check_val("abort_valid", int'(valid_n), 0);
        check_val("abort_angle", int'(angle_n), 0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_in);
            #1;
            if (valid_n === 1'b1 || valid_f === 1'b1)
                seen = 1;
        end
        check_val("abort_no_pulse", seen, 0);
        $display("vec abort amp=%08h reset mid-search", cur_amp);
        run_vec("after_abort", 32'h0000_B505, 45, 45);

        // Sweep exact table values in both signs.
        for (int d = 0; d <= 90; d++) begin
            r = $sin(real'(d) * 3.14159265358979323846 / 180.0) * 65536.0;
            v = $rtoi(r + 0.5);
            a = 32'(v);
            run_vec("sweep_pos", a, d, d);
            a = 32'd0 - a;
            run_vec("sweep_neg", a, (d == 0) ? 0 : 360 - d, (d == 0) ? 0 : 360 - d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
